alarm_set_ctrl: RTL and testbench

Button-driven controller that sequences alarm setting for the digital clock and fires the alarm.
- Lets the user step through hour and minute fields, increment BCD digits with wrap, and commit or abandon the edit.
- Holds the committed alarm time, compares it against running time and drives the ring output.
- Sits between the debounced button block and the display mux/buzzer driver.

---
 rtl/alarm_set_ctrl_pkg.sv | 17 +
 rtl/alarm_set_ctrl_if.sv | 32 +++
 rtl/alarm_set_ctrl_bcd2_wrap_inc.sv | 19 +
 rtl/alarm_set_ctrl.sv | 158 +++++++++++++++
 tb/tb_alarm_set_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_set_ctrl_pkg.sv
// rtl/alarm_set_ctrl_pkg.sv - shared types and BCD limits for the alarm setting controller
package alarm_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SET_HOUR = 3'd1,
    SET_MIN  = 3'd2,
    RING     = 3'd3,
    SNOOZE   = 3'd4
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] HOUR_MAX_BCD = 8'h23;
  localparam logic [7:0] MIN_MAX_BCD  = 8'h59;

endpackage

// File: rtl/alarm_set_ctrl_if.sv
// rtl/alarm_set_ctrl_if.sv - button, running-time and display/buzzer signals of the alarm controller
interface alarm_set_ctrl_if;

  logic           tick_1hz;
  logic           btn_mode;
  logic           btn_inc;
  logic           btn_stop;
  alarm_pkg::bcd_t cur_min1, cur_min2, cur_hour1, cur_hour2;
  alarm_pkg::bcd_t alarm_min1, alarm_min2, alarm_hour1, alarm_hour2;
  alarm_pkg::bcd_t edit_min1, edit_min2, edit_hour1, edit_hour2;
  logic           editing;
  logic           field_sel;
  logic           alarm_en;
  logic           ring;

  modport master (
    output tick_1hz, btn_mode, btn_inc, btn_stop,
    output cur_min1, cur_min2, cur_hour1, cur_hour2,
    input  alarm_min1, alarm_min2, alarm_hour1, alarm_hour2,
    input  edit_min1, edit_min2, edit_hour1, edit_hour2,
    input  editing, field_sel, alarm_en, ring
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc, btn_stop,
    input  cur_min1, cur_min2, cur_hour1, cur_hour2,
    output alarm_min1, alarm_min2, alarm_hour1, alarm_hour2,
    output edit_min1, edit_min2, edit_hour1, edit_hour2,
    output editing, field_sel, alarm_en, ring
  );

endinterface

// File: rtl/alarm_set_ctrl_bcd2_wrap_inc.sv
// rtl/alarm_set_ctrl_bcd2_wrap_inc.sv - two-digit BCD increment, wrapping to 00 past max_i
module bcd2_wrap_inc (
  input  logic [7:0] val_i,
  input  logic [7:0] max_i,
  output logic [7:0] inc_o
);

  // Packed BCD orders like binary, so >= also folds any out-of-range value back to 00.
  always_comb begin
    if (val_i >= max_i) begin
      inc_o = 8'h00;
    end else if (val_i[3:0] >= 4'd9) begin
      inc_o = {val_i[7:4] + 4'd1, 4'd0};
    end else begin
      inc_o = {val_i[7:4], val_i[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/alarm_set_ctrl.sv
// rtl/alarm_set_ctrl.sv - alarm edit/commit sequencer and ring control
// Optional snooze state is built when ALARM_SNOOZE_EN is defined.
module alarm_set_ctrl
  import alarm_pkg::*;
#(
  parameter int TIMEOUT_S = 10,
  parameter int RING_S    = 60,
  parameter int SNOOZE_S  = 300
) (
  input  logic           clk,
  input  logic           rst,
  alarm_set_ctrl_if.slave bus
);

  localparam int T_MAX2 = (TIMEOUT_S > RING_S) ? TIMEOUT_S : RING_S;
  localparam int T_MAX  = (T_MAX2 > SNOOZE_S) ? T_MAX2 : SNOOZE_S;
  localparam int TW     = $clog2(T_MAX + 1);

  state_e        state_q, state_d;
  logic [7:0]    alarm_hour_q, alarm_hour_d, alarm_min_q, alarm_min_d;
  logic [7:0]    edit_hour_q, edit_hour_d, edit_min_q, edit_min_d;
  logic          alarm_en_q, alarm_en_d;
  logic          match_q;
  logic [TW-1:0] tmr_q, tmr_d;

  logic [7:0] hour_inc, min_inc;
  logic       match, trigger, any_btn;

  bcd2_wrap_inc u_hour_inc (.val_i(edit_hour_q), .max_i(HOUR_MAX_BCD), .inc_o(hour_inc));
  bcd2_wrap_inc u_min_inc  (.val_i(edit_min_q),  .max_i(MIN_MAX_BCD),  .inc_o(min_inc));

  assign match   = alarm_en_q &
                   ({bus.cur_hour2, bus.cur_hour1, bus.cur_min2, bus.cur_min1} ==
                    {alarm_hour_q, alarm_min_q});
  assign trigger = match & ~match_q;
  assign any_btn = bus.btn_mode | bus.btn_inc | bus.btn_stop;

  // One timer serves every state: it is cleared on each state change.
  always_comb begin
    state_d      = state_q;
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    edit_hour_d  = edit_hour_q;
    edit_min_d   = edit_min_q;
    alarm_en_d   = alarm_en_q;
    tmr_d        = tmr_q;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (bus.btn_stop) begin
          alarm_en_d = ~alarm_en_q;
        end else if (bus.btn_mode) begin
          edit_hour_d = alarm_hour_q;
          edit_min_d  = alarm_min_q;
          state_d     = SET_HOUR;
        end else if (trigger) begin
          state_d = RING;
        end
      end
      SET_HOUR, SET_MIN: begin
        if (any_btn) begin
          tmr_d = '0;
        end else if (bus.tick_1hz) begin
          if (tmr_q == TW'(TIMEOUT_S - 1)) begin
            tmr_d   = '0;
            state_d = IDLE;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        // btn_stop outranks the edit buttons and otherwise does nothing here.
        if (!bus.btn_stop) begin
          if (bus.btn_mode) begin
            if (state_q == SET_HOUR) begin
              state_d = SET_MIN;
            end else begin
              alarm_hour_d = edit_hour_q;
              alarm_min_d  = edit_min_q;
              alarm_en_d   = 1'b1;
              state_d      = IDLE;
            end
          end else if (bus.btn_inc) begin
            if (state_q == SET_HOUR) edit_hour_d = hour_inc;
            else                     edit_min_d  = min_inc;
          end
        end
      end
      RING: begin
        if (bus.btn_stop) begin
          tmr_d = '0;
`ifdef ALARM_SNOOZE_EN
          state_d = SNOOZE;
`else
          state_d = IDLE;
`endif
        end else if (bus.tick_1hz) begin
          if (tmr_q == TW'(RING_S - 1)) begin
            tmr_d   = '0;
            state_d = IDLE;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (bus.btn_mode) begin
          tmr_d   = '0;
          state_d = IDLE;
        end else if (bus.tick_1hz) begin
          if (tmr_q == TW'(SNOOZE_S - 1)) begin
            tmr_d   = '0;
            state_d = RING;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      end
`endif
      default: begin
        tmr_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      alarm_hour_q <= 8'h00;
      alarm_min_q  <= 8'h00;
      edit_hour_q  <= 8'h00;
      edit_min_q   <= 8'h00;
      alarm_en_q   <= 1'b0;
      match_q      <= 1'b0;
      tmr_q        <= '0;
    end else begin
      state_q      <= state_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      edit_hour_q  <= edit_hour_d;
      edit_min_q   <= edit_min_d;
      alarm_en_q   <= alarm_en_d;
      match_q      <= match;
      tmr_q        <= tmr_d;
    end
  end

  assign {bus.alarm_hour2, bus.alarm_hour1} = alarm_hour_q;
  assign {bus.alarm_min2, bus.alarm_min1}   = alarm_min_q;
  assign {bus.edit_hour2, bus.edit_hour1}   = edit_hour_q;
  assign {bus.edit_min2, bus.edit_min1}     = edit_min_q;
  assign bus.alarm_en  = alarm_en_q;
  assign bus.editing   = (state_q == SET_HOUR) || (state_q == SET_MIN);
  assign bus.field_sel = (state_q == SET_MIN);
  assign bus.ring      = (state_q == RING);

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// tb/tb_alarm_set_ctrl.sv - directed and randomized checks of alarm_set_ctrl against an integer-time model
module tb_alarm_set_ctrl;

  localparam int TIMEOUT_S = 10;
  localparam int RING_S    = 60;
  localparam int SNOOZE_S  = 5;

  localparam int M_IDLE = 0, M_HOUR = 1, M_MIN = 2, M_RING = 3, M_SNOOZE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alarm_set_ctrl_if bus ();

  alarm_set_ctrl #(.TIMEOUT_S(TIMEOUT_S), .RING_S(RING_S), .SNOOZE_S(SNOOZE_S)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: times as plain integers, phases and counters as ints.
  int  m_st, m_ah, m_am, m_eh, m_em, m_idle, m_rc, m_sc;
  bit  m_en, m_prev;
  int  cur_h = 0, cur_m = 0;

  function automatic logic [7:0] to_bcd(int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_cur(int h, int m);
    cur_h = h;
    cur_m = m;
    {bus.cur_hour2, bus.cur_hour1} = to_bcd(h);
    {bus.cur_min2, bus.cur_min1}   = to_bcd(m);
  endtask

  task automatic model_step(bit t, bit md, bit inc, bit st);
    bit match;
    if (rst) begin
      m_st = M_IDLE; m_ah = 0; m_am = 0; m_eh = 0; m_em = 0;
      m_en = 0; m_prev = 0; m_idle = 0; m_rc = 0; m_sc = 0;
      return;
    end
    match = m_en && (cur_h == m_ah) && (cur_m == m_am);
    case (m_st)
      M_IDLE: begin
        if (st) m_en = !m_en;
        else if (md) begin m_eh = m_ah; m_em = m_am; m_idle = 0; m_st = M_HOUR; end
        else if (match && !m_prev) begin m_rc = 0; m_st = M_RING; end
      end
      M_HOUR, M_MIN: begin
        if (st || md || inc) m_idle = 0;
        else if (t) begin
          m_idle++;
          if (m_idle == TIMEOUT_S) m_st = M_IDLE;
        end
        if (!st && md) begin
          if (m_st == M_HOUR) m_st = M_MIN;
          else begin m_ah = m_eh; m_am = m_em; m_en = 1; m_st = M_IDLE; end
        end else if (!st && inc) begin
          if (m_st == M_HOUR) m_eh = (m_eh + 1) % 24;
          else                m_em = (m_em + 1) % 60;
        end
      end
      M_RING: begin
        if (st) begin
`ifdef ALARM_SNOOZE_EN
          m_sc = 0; m_st = M_SNOOZE;
`else
          m_st = M_IDLE;
`endif
        end else if (t) begin
          m_rc++;
          if (m_rc == RING_S) m_st = M_IDLE;
        end
      end
      M_SNOOZE: begin
        if (md) m_st = M_IDLE;
        else if (t) begin
          m_sc++;
          if (m_sc == SNOOZE_S) begin m_rc = 0; m_st = M_RING; end
        end
      end
      default: m_st = M_IDLE;
    endcase
    m_prev = match;
  endtask

  task automatic compare_all();
    check("alarm", {16'h0, bus.alarm_hour2, bus.alarm_hour1, bus.alarm_min2, bus.alarm_min1},
          {16'h0, to_bcd(m_ah), to_bcd(m_am)});
    check("edit", {16'h0, bus.edit_hour2, bus.edit_hour1, bus.edit_min2, bus.edit_min1},
          {16'h0, to_bcd(m_eh), to_bcd(m_em)});
    check("alarm_en", 32'(bus.alarm_en), 32'(m_en));
    check("editing", 32'(bus.editing), 32'((m_st == M_HOUR) || (m_st == M_MIN)));
    check("field_sel", 32'(bus.field_sel), 32'(m_st == M_MIN));
    check("ring", 32'(bus.ring), 32'(m_st == M_RING));
  endtask

  // Drives one clock of inputs (from a negedge), steps the model, compares at the next negedge.
  task automatic cyc(bit t, bit md, bit inc, bit st);
    bus.tick_1hz = t;
    bus.btn_mode = md;
    bus.btn_inc  = inc;
    bus.btn_stop = st;
    model_step(t, md, inc, st);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic incs(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0);
  endtask

  function automatic logic [31:0] alarm_word();
    return {16'h0, bus.alarm_hour2, bus.alarm_hour1, bus.alarm_min2, bus.alarm_min1};
  endfunction

  initial begin
    bus.tick_1hz = 0; bus.btn_mode = 0; bus.btn_inc = 0; bus.btn_stop = 0;
    set_cur(12, 34);
    @(negedge clk);
    rst = 1;
    cyc(0, 0, 0, 0);
    rst = 0;
    check("reset_alarm", alarm_word(), 32'h0);
    check("reset_ring", 32'(bus.ring), 32'h0);

    // 1: 03:02 via three hour and two minute increments
    cyc(0, 1, 0, 0); incs(3); cyc(0, 1, 0, 0); incs(2); cyc(0, 1, 0, 0);
    check("t1_alarm", alarm_word(), 32'h0302);
    check("t1_en", 32'(bus.alarm_en), 32'h1);
    check("t1_editing", 32'(bus.editing), 32'h0);

    // 2: reach 23:59, then wrap both fields with no carry
    cyc(0, 1, 0, 0); incs(20); cyc(0, 1, 0, 0); incs(57); cyc(0, 1, 0, 0);
    check("t2_2359", alarm_word(), 32'h2359);
    cyc(0, 1, 0, 0); incs(1); cyc(0, 1, 0, 0); incs(1); cyc(0, 1, 0, 0);
    check("t2_wrap", alarm_word(), 32'h0000);

    // 3: 07:30 armed, ring on entering the minute, 60 ticks, no retrigger
    cyc(0, 1, 0, 0); incs(7); cyc(0, 1, 0, 0); incs(30); cyc(0, 1, 0, 0);
    check("t3_alarm", alarm_word(), 32'h0730);
    set_cur(7, 29); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    check("t3_pre_ring", 32'(bus.ring), 32'h0);
    set_cur(7, 30); cyc(0, 0, 0, 0);
    check("t3_ring_on", 32'(bus.ring), 32'h1);
    for (int i = 1; i < RING_S; i++) begin
      cyc(1, 0, 0, 0);
      check("t3_ring_hold", 32'(bus.ring), 32'h1);
    end
    cyc(1, 0, 0, 0);
    check("t3_ring_off", 32'(bus.ring), 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0);
      check("t3_no_retrig", 32'(bus.ring), 32'h0);
    end

    // 4: timeout in SET_MIN
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); incs(4);
    for (int i = 1; i < TIMEOUT_S; i++) cyc(1, 0, 0, 0);
    check("t4_still_edit", 32'(bus.editing), 32'h1);
    cyc(1, 0, 0, 0);
    check("t4_timeout", 32'(bus.editing), 32'h0);
    check("t4_alarm_kept", alarm_word(), 32'h0730);

    // 5: stop+inc in RING, then rst mid-SET_HOUR
    set_cur(12, 0); cyc(0, 0, 0, 0);
    set_cur(7, 30); cyc(0, 0, 0, 0);
    check("t5_ring_on", 32'(bus.ring), 32'h1);
    cyc(0, 0, 1, 1);
    check("t5_ring_off", 32'(bus.ring), 32'h0);
    check("t5_edit_same", {16'h0, bus.edit_hour2, bus.edit_hour1, bus.edit_min2, bus.edit_min1},
          32'h0734);
    cyc(0, 1, 0, 0); incs(1);
    check("t5_in_edit", 32'(bus.editing), 32'h1);
    rst = 1; cyc(0, 0, 0, 0); rst = 0;
    check("t5_rst_alarm", alarm_word(), 32'h0);
    check("t5_rst_en", 32'(bus.alarm_en), 32'h0);
    check("t5_rst_editing", 32'(bus.editing), 32'h0);

`ifdef ALARM_SNOOZE_EN
    // 6: snooze for SNOOZE_S ticks, then ring again
    set_cur(12, 0); cyc(0, 0, 0, 1);
    set_cur(0, 0); cyc(0, 0, 0, 0);
    check("t6_ring_on", 32'(bus.ring), 32'h1);
    cyc(0, 0, 0, 1);
    check("t6_snooze", 32'(bus.ring), 32'h0);
    for (int i = 1; i < SNOOZE_S; i++) cyc(1, 0, 0, 0);
    check("t6_still_snooze", 32'(bus.ring), 32'h0);
    cyc(1, 0, 0, 0);
    check("t6_ring_again", 32'(bus.ring), 32'h1);
`endif

    // Random phase: sparse buttons, frequent ticks, running time often steered onto the alarm.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 1) == 1) set_cur(m_ah, m_am);
        else set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
      end
      rst = ($urandom_range(0, 799) == 0);
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0);
      rst = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
